// File: rtl/demux1x8_wb.sv
// demux1x8_wb: write-back distributor.
// Queues {sel, data} writes in a small FIFO and, when the head entry's
// destination is not held, writes its data into one of eight registered
// outputs and strobes the matching upd bit for one cycle.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_data, in_sel   value and destination index (0 -> out1, 7 -> out8)
//   in_valid/in_ready push handshake
//   clear             synchronous flush of queued entries (outputs kept)
//   hold[7:0]         hold[i] blocks writes to out(i+1)
//   out1..out8        registered destination values
//   upd[7:0]          one-cycle strobe: out(i+1) was written at the last edge
//   busy              FIFO non-empty
module demux1x8_wb #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
  input  logic [7:0]       hold,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7,
  output logic [WIDTH-1:0] out8,
  output logic [7:0]       upd,
  output logic             busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH+2:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] outs [8];

  logic [2:0]       head_sel;
  logic [WIDTH-1:0] head_data;
  logic             push;
  logic             pop;

  assign head_sel  = mem[rd_ptr][WIDTH+2:WIDTH];
  assign head_data = mem[rd_ptr][WIDTH-1:0];

  assign in_ready = (count != FULL_CNT);
  assign busy     = (count != '0);

  // clear wins over both sides of the queue in the same cycle
  assign push = in_valid && in_ready && !clear;
  assign pop  = busy && !hold[head_sel] && !clear;

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_sel, in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) outs[i] <= '0;
      upd <= '0;
    end else begin
      upd <= '0;
      if (pop) begin
        outs[head_sel] <= head_data;
        upd            <= 8'b1 << head_sel;
      end
    end
  end

  assign out1 = outs[0];
  assign out2 = outs[1];
  assign out3 = outs[2];
  assign out4 = outs[3];
  assign out5 = outs[4];
  assign out6 = outs[5];
  assign out7 = outs[6];
  assign out8 = outs[7];

endmodule

// File: tb/tb_demux1x8_wb.sv
module tb_demux1x8_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic [2:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic        clear;
  logic [7:0]  hold;
  logic [15:0] outs [8];
  logic [7:0]  upd;
  logic        busy;

  int errors = 0;
  int checks = 0;

  demux1x8_wb #(.WIDTH(16), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .clear(clear), .hold(hold),
    .out1(outs[0]), .out2(outs[1]), .out3(outs[2]), .out4(outs[3]),
    .out5(outs[4]), .out6(outs[5]), .out7(outs[6]), .out8(outs[7]),
    .upd(upd), .busy(busy)
  );

  always #5 clk = ~clk;

  // advance one rising edge, then settle before driving/sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_data = '0; in_sel = '0; in_valid = 1'b0;
    clear = 1'b0; hold = '0;
    #3;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (outs[i] !== 16'h0) begin
        errors++; $display("FAIL reset_out%0d got %h exp 0000", i + 1, outs[i]);
      end
    end
    checks++;
    if (upd !== 8'h00 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_flags upd=%h busy=%b rdy=%b exp 00 0 1", upd, busy, in_ready);
    end
    step(); step();
    rst_n = 1'b1;
    step();
    checks++;
    if (upd !== 8'h00 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release upd=%h busy=%b exp 00 0", upd, busy);
    end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_sel = 3'd5; in_data = 16'hBEEF;
    step();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || upd !== 8'h00 || outs[5] !== 16'h0) begin
      errors++; $display("FAIL single_accept busy=%b upd=%h out6=%h exp 1 00 0000", busy, upd, outs[5]);
    end
    step();
    checks++;
    if (outs[5] !== 16'hBEEF || upd !== 8'b0010_0000) begin
      errors++; $display("FAIL single_write out6=%h upd=%h exp beef 20", outs[5], upd);
    end
    checks++;
    if (outs[0] !== 0 || outs[1] !== 0 || outs[2] !== 0 || outs[3] !== 0 ||
        outs[4] !== 0 || outs[6] !== 0 || outs[7] !== 0) begin
      errors++; $display("FAIL single_others out1=%h out8=%h exp all 0000", outs[0], outs[7]);
    end
    // same value again still strobes
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (outs[5] !== 16'hBEEF || upd !== 8'b0010_0000) begin
      errors++; $display("FAIL single_same out6=%h upd=%h exp beef 20", outs[5], upd);
    end
    step();
    checks++;
    if (upd !== 8'h00 || busy !== 1'b0) begin
      errors++; $display("FAIL single_idle upd=%h busy=%b exp 00 0", upd, busy);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_sel = 3'(i); in_data = 16'h1000 + 16'(i);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready i=%0d got %b exp 1", i, in_ready);
      end
      step();
      if (i >= 1) begin
        checks++;
        if (upd !== (8'b1 << (i - 1))) begin
          errors++; $display("FAIL b2b_upd i=%0d got %h exp %h", i, upd, 8'b1 << (i - 1));
        end
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (upd !== 8'h80) begin
      errors++; $display("FAIL b2b_upd_last got %h exp 80", upd);
    end
    step();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (outs[i] !== 16'h1000 + 16'(i)) begin
        errors++; $display("FAIL b2b_out%0d got %h exp %h", i + 1, outs[i], 16'h1000 + 16'(i));
      end
    end
  endtask

  task automatic test_reset_mid();
    hold = 8'hFF;
    in_valid = 1'b1; in_sel = 3'd0; in_data = 16'h0DD0;
    step();
    in_sel = 3'd1; in_data = 16'h0DD1;
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (outs[i] !== 16'h0) begin
        errors++; $display("FAIL midrst_out%0d got %h exp 0000", i + 1, outs[i]);
      end
    end
    checks++;
    if (upd !== 8'h00 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_flags upd=%h busy=%b rdy=%b exp 00 0 1", upd, busy, in_ready);
    end
    hold = 8'h00;
    step();
    rst_n = 1'b1;
    step(); step();
    checks++;
    if (upd !== 8'h00 || busy !== 1'b0 || outs[0] !== 16'h0 || outs[1] !== 16'h0) begin
      errors++; $display("FAIL midrst_release upd=%h busy=%b out1=%h out2=%h exp 00 0 0000 0000",
                         upd, busy, outs[0], outs[1]);
    end
  endtask

  task automatic test_hold();
    hold = 8'b0000_0100;
    in_valid = 1'b1; in_sel = 3'd2; in_data = 16'hAAAA;
    step();
    in_sel = 3'd3; in_data = 16'h5555;
    step();
    in_sel = 3'd1; in_data = 16'h7777;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL hold_full_ready got %b exp 0", in_ready);
    end
    step(); step();
    checks++;
    if (outs[2] !== 16'h0 || outs[3] !== 16'h0 || upd !== 8'h00 || in_ready !== 1'b0) begin
      errors++; $display("FAIL hold_blocked out3=%h out4=%h upd=%h rdy=%b exp 0000 0000 00 0",
                         outs[2], outs[3], upd, in_ready);
    end
    hold = 8'h00;
    step();
    checks++;
    if (outs[2] !== 16'hAAAA || outs[3] !== 16'h0 || upd !== 8'b0000_0100) begin
      errors++; $display("FAIL hold_rel_out3 out3=%h out4=%h upd=%h exp aaaa 0000 04", outs[2], outs[3], upd);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (outs[3] !== 16'h5555 || upd !== 8'b0000_1000 || outs[2] !== 16'hAAAA) begin
      errors++; $display("FAIL hold_rel_out4 out4=%h upd=%h out3=%h exp 5555 08 aaaa", outs[3], upd, outs[2]);
    end
    step();
    checks++;
    if (outs[1] !== 16'h7777 || upd !== 8'b0000_0010) begin
      errors++; $display("FAIL hold_third out2=%h upd=%h exp 7777 02", outs[1], upd);
    end
    step();
    checks++;
    if (busy !== 1'b0 || upd !== 8'h00) begin
      errors++; $display("FAIL hold_drain busy=%b upd=%h exp 0 00", busy, upd);
    end
  endtask

  task automatic test_clear();
    hold = 8'hFF;
    in_valid = 1'b1; in_sel = 3'd0; in_data = 16'h1111;
    step();
    in_sel = 3'd1; in_data = 16'h2222;
    step();
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL clear_pre busy=%b rdy=%b exp 1 0", busy, in_ready);
    end
    // release holds in the clear cycle: clear must also suppress the pop
    clear = 1'b1; hold = 8'h00; in_sel = 3'd2; in_data = 16'h3333;
    step();
    clear = 1'b0; in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || upd !== 8'h00 || outs[0] !== 16'h0) begin
      errors++; $display("FAIL clear_edge busy=%b rdy=%b upd=%h out1=%h exp 0 1 00 0000",
                         busy, in_ready, upd, outs[0]);
    end
    step(); step();
    checks++;
    if (busy !== 1'b0 || upd !== 8'h00 || outs[0] !== 16'h0 ||
        outs[1] !== 16'h7777 || outs[2] !== 16'hAAAA) begin
      errors++; $display("FAIL clear_after busy=%b upd=%h out1=%h out2=%h out3=%h exp 0 00 0000 7777 aaaa",
                         busy, upd, outs[0], outs[1], outs[2]);
    end
  endtask

  task automatic test_wrap();
    logic [2:0] s;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_sel   = (k % 2 == 0) ? 3'd7 : 3'd0;
      in_data  = 16'(k + 1);
      step();
      if (k >= 1) begin
        s = ((k - 1) % 2 == 0) ? 3'd7 : 3'd0;
        checks++;
        if (upd !== (8'b1 << s) || outs[s] !== 16'(k)) begin
          errors++; $display("FAIL wrap_k%0d upd=%h out%0d=%h exp %h %h", k - 1, upd, s + 1, outs[s],
                             8'b1 << s, 16'(k));
        end
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (upd !== 8'h01 || outs[0] !== 16'h000A) begin
      errors++; $display("FAIL wrap_last upd=%h out1=%h exp 01 000a", upd, outs[0]);
    end
    step();
    checks++;
    if (upd !== 8'h00 || busy !== 1'b0 || outs[7] !== 16'h0009 || outs[0] !== 16'h000A) begin
      errors++; $display("FAIL wrap_final upd=%h busy=%b out8=%h out1=%h exp 00 0 0009 000a",
                         upd, busy, outs[7], outs[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_hold();
    test_clear();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
